// File: rtl/fmap_axis_streamer.sv
// Streams one square feature map from a 1-cycle-latency BRAM read port onto a master AXI-Stream.
// Build macro FMAP_ROW_TLAST_EN: tlast marks the end of every row rather than only the end of the frame.
module fmap_axis_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            Image_size,
    output logic                  busy,
    output logic                  done,
    output logic                  size_err,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      total_q;
    logic [CNT_W-1:0]      rd_cnt;
    logic                  rd_vld;
    logic                  rd_last;
    logic                  sp_vld;
    logic                  sp_last;
    logic [DATA_WIDTH-1:0] sp_data;
    logic                  size_ok;
    logic                  accept;
    logic                  pop;
    logic                  issue_last;
    logic                  issue_tag;
    logic                  credit_ok;
    logic [1:0]            credit;

    always_comb begin
        size_ok = 1'b0;
        case (Image_size)
            8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128: size_ok = 1'b1;
            default:                                 size_ok = 1'b0;
        endcase
    end

    assign accept     = (state == IDLE) && start;
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign issue_last = (rd_cnt == total_q - CNT_W'(1));
    assign bram_addr  = rd_cnt[ADDR_WIDTH-1:0];

    // Entries held or returning after this cycle's pop; a new read must still fit in two slots.
    // The read enable is decoded combinationally so a freed slot can be refilled in the same cycle,
    // which is what sustains one beat per clock with only two buffer entries.
    assign credit    = 2'(m_axis_tvalid) + 2'(sp_vld) - 2'(pop) + 2'(rd_vld);
    assign credit_ok = (credit < 2'd2);

`ifdef FMAP_ROW_TLAST_EN
    logic [7:0] size_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q <= 8'd0;
        end else if (accept && size_ok) begin
            size_q <= Image_size;
        end
    end

    assign issue_tag = issue_last || ((8'(rd_cnt) & (size_q - 8'd1)) == (size_q - 8'd1));
`else
    assign issue_tag = issue_last;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = size_ok ? RUN : FIN;
            RUN:   if (credit_ok && issue_last) state_nxt = DRAIN;
            DRAIN: if (!rd_vld && !sp_vld && (!m_axis_tvalid || pop)) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        bram_en = 1'b0;
        case (state)
            RUN:     begin busy = 1'b1; bram_en = credit_ok; end
            DRAIN:   busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // Frame setup, read counter and read-return tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q  <= '0;
            rd_cnt   <= '0;
            size_err <= 1'b0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_vld  <= bram_en;
            rd_last <= bram_en && issue_tag;
            if (accept) begin
                rd_cnt   <= '0;
                size_err <= !size_ok;
                if (size_ok) begin
                    total_q <= CNT_W'(Image_size) * CNT_W'(Image_size);
                end
            end else if (bram_en) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
        end
    end

    // Two-entry output buffer: the head registers are the AXIS outputs, the spare catches a stalled return
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            sp_vld        <= 1'b0;
            sp_data       <= '0;
            sp_last       <= 1'b0;
        end else if (rd_vld) begin
            if (!m_axis_tvalid || (pop && !sp_vld)) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= bram_dout;
                m_axis_tlast  <= rd_last;
            end else if (pop) begin
                m_axis_tdata <= sp_data;
                m_axis_tlast <= sp_last;
                sp_data      <= bram_dout;
                sp_last      <= rd_last;
            end else begin
                sp_vld  <= 1'b1;
                sp_data <= bram_dout;
                sp_last <= rd_last;
            end
        end else if (pop) begin
            if (sp_vld) begin
                m_axis_tdata <= sp_data;
                m_axis_tlast <= sp_last;
                sp_vld       <= 1'b0;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
